// File: rtl/text_console_pkg.sv
// Shared constants for the on-screen text buffer: screen geometry, control codes
// and the writer state encoding. The glyph renderer imports the same geometry.
package text_console_pkg;

  localparam int DEF_COLS   = 80;   // 640 px / 8 px glyph
  localparam int DEF_ROWS   = 30;   // 480 px / 16 px glyph
  localparam int DEF_ADDR_W = 12;

  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_BS    = 8'h08;
  localparam logic [7:0] ASC_FF    = 8'h0C;
  localparam logic [7:0] ASC_TILDE = 8'h7E;

  typedef enum logic [1:0] {
    CLR_ALL  = 2'd0,
    IDLE     = 2'd1,
    CLR_LINE = 2'd2
  } state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= ASC_SPACE) && (c <= ASC_TILDE);
  endfunction

endpackage

// File: rtl/text_console_writer.sv
// Writer side of the character RAM: accepts ASCII over valid/ready, tracks the
// cursor, interprets LF/CR/BS/FF and clears lines as the cursor enters them.
module text_console_writer
  import text_console_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              char_valid,
  input  logic [7:0]        char_ascii,
  output logic              char_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] CELL_LAST = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] LINE_LAST = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [6:0]        COL_LAST  = 7'(COLS - 1);
  localparam logic [4:0]        ROW_LAST  = 5'(ROWS - 1);

  state_t            state;
  logic [ADDR_W-1:0] row_base;   // cursor_row * COLS, kept incrementally
  logic [ADDR_W-1:0] clr_cnt;

  logic              accept;
  logic              printable;
  logic              at_last_col;
  logic              row_advance;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] next_base;
  logic [4:0]        next_row;

  // NOTE: every signal gets a value on every path through this block; a missing
  // assignment on some branch would infer a latch.
  always_comb begin
    accept      = (state == IDLE) && char_valid && char_ready;
    printable   = is_printable(char_ascii);
    at_last_col = (cursor_col == COL_LAST);
    row_advance = (printable && at_last_col) || (char_ascii == ASC_LF);
    cur_addr    = row_base + ADDR_W'(cursor_col);
    if (cursor_row == ROW_LAST) begin
      next_row  = '0;
      next_base = '0;
    end else begin
      next_row  = cursor_row + 5'd1;
      next_base = row_base + ROW_STEP;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples
  // the pre-edge values; later assignments in the block override earlier ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLR_ALL;
      row_base   <= '0;
      clr_cnt    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      char_ready <= 1'b0;
      busy       <= 1'b1;
    end else begin
      wr_en <= 1'b0;
      case (state)
        // NOTE: the character RAM itself has no reset; this sweep is what puts it
        // into a known (blank) state.
        CLR_ALL: begin
          wr_en      <= 1'b1;
          wr_addr    <= clr_cnt;
          wr_data    <= ASC_SPACE;
          char_ready <= 1'b0;
          busy       <= 1'b1;
          if (clr_cnt == CELL_LAST) begin
            clr_cnt <= '0;
            state   <= IDLE;
          end else begin
            clr_cnt <= clr_cnt + ADDR_ONE;
          end
        end

        CLR_LINE: begin
          wr_en      <= 1'b1;
          wr_addr    <= row_base + clr_cnt;
          wr_data    <= ASC_SPACE;
          char_ready <= 1'b0;
          busy       <= 1'b1;
          if (clr_cnt == LINE_LAST) begin
            clr_cnt <= '0;
            state   <= IDLE;
          end else begin
            clr_cnt <= clr_cnt + ADDR_ONE;
          end
        end

        IDLE: begin
          // ready rises here, one cycle after the last clear write became visible
          char_ready <= 1'b1;
          busy       <= 1'b0;
          if (accept) begin
            if (printable) begin
              wr_en   <= 1'b1;
              wr_addr <= cur_addr;
              wr_data <= char_ascii;
              if (!at_last_col) cursor_col <= cursor_col + 7'd1;
            end
            if (row_advance) begin
              cursor_col <= '0;
              cursor_row <= next_row;
              row_base   <= next_base;
              clr_cnt    <= '0;
              state      <= CLR_LINE;
              char_ready <= 1'b0;
              busy       <= 1'b1;
            end else if (char_ascii == ASC_CR) begin
              cursor_col <= '0;
            end else if (char_ascii == ASC_BS && cursor_col != '0) begin
              cursor_col <= cursor_col - 7'd1;
              wr_en      <= 1'b1;
              wr_addr    <= cur_addr - ADDR_ONE;
              wr_data    <= ASC_SPACE;
            end else if (char_ascii == ASC_FF) begin
              cursor_col <= '0;
              cursor_row <= '0;
              row_base   <= '0;
              clr_cnt    <= '0;
              state      <= CLR_ALL;
              char_ready <= 1'b0;
              busy       <= 1'b1;
            end
          end
        end

        default: begin
          clr_cnt    <= '0;
          state      <= CLR_ALL;
          char_ready <= 1'b0;
          busy       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: table of single-code vectors plus
// hand-written sequences for clears, wrap-around, backspace and reset abort.
module tb_text_console_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        char_valid = 1'b0;
  logic [7:0]  char_ascii = 8'h00;
  logic        char_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  int tests = 0;
  int fails = 0;

  text_console_writer dut (
    .clk        (clk),
    .rst        (rst),
    .char_valid (char_valid),
    .char_ascii (char_ascii),
    .char_ready (char_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0]  code;
    logic        exp_wr;
    logic [11:0] exp_addr;
    logic [7:0]  exp_data;
    logic [6:0]  exp_col;
    logic [4:0]  exp_row;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (char_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, " ready in time"}, {31'd0, char_ready}, 32'd1);
  endtask

  // Presents one code; returns on the negedge after the accepting edge.
  task automatic send(input string name, input logic [7:0] code);
    wait_ready(name);
    char_valid = 1'b1;
    char_ascii = code;
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  // Expects count consecutive blank writes starting at start, beginning next cycle.
  task automatic check_clear(input string name, input int start, input int count);
    int bad;
    bad = 0;
    for (int i = 0; i < count; i++) begin
      @(negedge clk);
      if (wr_en !== 1'b1 || wr_addr !== 12'(start + i) || wr_data !== 8'h20 ||
          busy !== 1'b1 || char_ready !== 1'b0) begin
        if (bad == 0)
          $display("  %s: first bad cell %0d wr_en=%0b addr=%0d data=%02h busy=%0b ready=%0b",
                   name, i, wr_en, wr_addr, wr_data, busy, char_ready);
        bad++;
      end
    end
    check({name, " bad clear cells"}, 32'(bad), 32'd0);
  endtask

  function automatic logic [7:0] code_of(input int i);
    return 8'h41 + 8'(i % 26);
  endfunction

  initial begin
    int bad;

    //           code   wr    addr    data   col    row
    vecs[0]  = '{8'h0D, 1'b0, 12'd0, 8'h00, 7'd0, 5'd0};  // CR from col 2
    vecs[1]  = '{8'h41, 1'b1, 12'd0, 8'h41, 7'd1, 5'd0};
    vecs[2]  = '{8'h42, 1'b1, 12'd1, 8'h42, 7'd2, 5'd0};
    vecs[3]  = '{8'h43, 1'b1, 12'd2, 8'h43, 7'd3, 5'd0};
    vecs[4]  = '{8'h08, 1'b1, 12'd2, 8'h20, 7'd2, 5'd0};  // BS blanks new cell
    vecs[5]  = '{8'h07, 1'b0, 12'd0, 8'h00, 7'd2, 5'd0};  // BEL ignored
    vecs[6]  = '{8'h7F, 1'b0, 12'd0, 8'h00, 7'd2, 5'd0};  // DEL ignored
    vecs[7]  = '{8'h7E, 1'b1, 12'd2, 8'h7E, 7'd3, 5'd0};  // highest printable
    vecs[8]  = '{8'h20, 1'b1, 12'd3, 8'h20, 7'd4, 5'd0};  // lowest printable
    vecs[9]  = '{8'h1F, 1'b0, 12'd0, 8'h00, 7'd4, 5'd0};
    vecs[10] = '{8'h0D, 1'b0, 12'd0, 8'h00, 7'd0, 5'd0};
    vecs[11] = '{8'h08, 1'b0, 12'd0, 8'h00, 7'd0, 5'd0};  // BS at col 0
    vecs[12] = '{8'hFF, 1'b0, 12'd0, 8'h00, 7'd0, 5'd0};

    // Reset values, then the full-screen clear
    repeat (3) @(negedge clk);
    check("rst wr_en", {31'd0, wr_en}, 32'd0);
    check("rst wr_addr", 32'(wr_addr), 32'd0);
    check("rst wr_data", 32'(wr_data), 32'd0);
    check("rst ready", {31'd0, char_ready}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd1);
    check("rst cursor", {20'd0, cursor_row, cursor_col}, 32'd0);
    rst = 1'b0;
    check_clear("init clear", 0, 2400);
    @(negedge clk);
    check("init ready", {31'd0, char_ready}, 32'd1);
    check("init busy", {31'd0, busy}, 32'd0);
    check("init wr_en idle", {31'd0, wr_en}, 32'd0);
    check("init cursor", {20'd0, cursor_row, cursor_col}, 32'd0);

    // "HI" back to back
    char_valid = 1'b1;
    char_ascii = 8'h48;
    @(negedge clk);
    check("HI wr_en H", {31'd0, wr_en}, 32'd1);
    check("HI addr H", 32'(wr_addr), 32'd0);
    check("HI data H", 32'(wr_data), 32'h48);
    char_ascii = 8'h49;
    @(negedge clk);
    check("HI wr_en I", {31'd0, wr_en}, 32'd1);
    check("HI addr I", 32'(wr_addr), 32'd1);
    check("HI data I", 32'(wr_data), 32'h49);
    check("HI col", 32'(cursor_col), 32'd2);
    char_valid = 1'b0;
    @(negedge clk);
    check("HI wr_en after", {31'd0, wr_en}, 32'd0);

    // Single-code vectors
    for (int v = 0; v < 13; v++) begin
      send($sformatf("vec%0d", v), vecs[v].code);
      check($sformatf("vec%0d wr_en", v), {31'd0, wr_en}, {31'd0, vecs[v].exp_wr});
      check($sformatf("vec%0d col", v), 32'(cursor_col), 32'(vecs[v].exp_col));
      check($sformatf("vec%0d row", v), 32'(cursor_row), 32'(vecs[v].exp_row));
      if (vecs[v].exp_wr) begin
        check($sformatf("vec%0d addr", v), 32'(wr_addr), 32'(vecs[v].exp_addr));
        check($sformatf("vec%0d data", v), 32'(wr_data), 32'(vecs[v].exp_data));
      end
    end

    // 80 characters fill row 0, wrap clears row 1; 'Z' is held during the clear
    bad = 0;
    char_valid = 1'b1;
    char_ascii = code_of(0);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (wr_en !== 1'b1 || wr_addr !== 12'(i) || wr_data !== code_of(i) ||
          char_ready !== (i < 79)) bad++;
      char_ascii = (i < 79) ? code_of(i + 1) : 8'h5A;
    end
    check("row fill bad writes", 32'(bad), 32'd0);
    check("row fill cursor", {20'd0, cursor_row, cursor_col}, {20'd0, 5'd1, 7'd0});
    check_clear("row1 clear", 80, 80);
    @(negedge clk);
    check("row1 ready after", {31'd0, char_ready}, 32'd1);
    @(negedge clk);
    char_valid = 1'b0;
    check("held Z wr_en", {31'd0, wr_en}, 32'd1);
    check("held Z addr", 32'(wr_addr), 32'd80);
    check("held Z data", 32'(wr_data), 32'h5A);
    check("held Z col", 32'(cursor_col), 32'd1);

    // Newline to row 2, then backspace at col 3 row 2
    send("lf row2", 8'h0A);
    check("lf no char write", {31'd0, wr_en}, 32'd0);
    check("lf cursor", {20'd0, cursor_row, cursor_col}, {20'd0, 5'd2, 7'd0});
    check_clear("row2 clear", 160, 80);
    send("x", 8'h78);
    send("y", 8'h79);
    send("z", 8'h7A);
    check("z addr", 32'(wr_addr), 32'd162);
    send("bs row2", 8'h08);
    check("bs wr_en", {31'd0, wr_en}, 32'd1);
    check("bs addr", 32'(wr_addr), 32'd162);
    check("bs data", 32'(wr_data), 32'h20);
    check("bs col", 32'(cursor_col), 32'd2);

    // Walk down to row 29, col 5, then newline wraps to row 0
    for (int k = 0; k < 27; k++) send("lf walk", 8'h0A);
    wait_ready("walk end");
    check("walk cursor", {20'd0, cursor_row, cursor_col}, {20'd0, 5'd29, 7'd0});
    for (int j = 0; j < 5; j++) send("row29 char", 8'h61 + 8'(j));
    check("row29 addr", 32'(wr_addr), 32'd2324);
    check("row29 data", 32'(wr_data), 32'h65);
    check("row29 col", 32'(cursor_col), 32'd5);
    send("lf wrap", 8'h0A);
    check("wrap no char write", {31'd0, wr_en}, 32'd0);
    check("wrap cursor", {20'd0, cursor_row, cursor_col}, 32'd0);
    check_clear("wrap clear", 0, 80);
    @(negedge clk);
    check("wrap ready after", {31'd0, char_ready}, 32'd1);

    // Form feed mid-screen, then reset during the resulting clear
    send("Q", 8'h51);
    check("Q addr", 32'(wr_addr), 32'd0);
    check("Q col", 32'(cursor_col), 32'd1);
    send("ff", 8'h0C);
    check("ff wr_en", {31'd0, wr_en}, 32'd0);
    check("ff ready", {31'd0, char_ready}, 32'd0);
    check("ff busy", {31'd0, busy}, 32'd1);
    check("ff cursor", {20'd0, cursor_row, cursor_col}, 32'd0);
    check_clear("ff clear head", 0, 100);
    rst = 1'b1;
    @(negedge clk);
    check("abort wr_en", {31'd0, wr_en}, 32'd0);
    check("abort addr", 32'(wr_addr), 32'd0);
    check("abort data", 32'(wr_data), 32'd0);
    check("abort ready", {31'd0, char_ready}, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    check_clear("restart clear", 0, 2400);
    @(negedge clk);
    check("restart ready", {31'd0, char_ready}, 32'd1);
    check("restart busy", {31'd0, busy}, 32'd0);
    check("restart cursor", {20'd0, cursor_row, cursor_col}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Writer side of the on-screen text buffer; the glyph renderer reads the same buffer.
- Accepts a stream of ASCII characters from game logic through a valid/ready handshake.
- Maintains a cursor and writes character codes into the character RAM (COLS x ROWS cells, row-major) through a single write port.
- Interprets control codes: newline, carriage return, backspace and form-feed (clear screen). Clears a row whenever the cursor enters it.

Parameters:
- COLS, 80, characters per row (640 px / 8 px glyph)
- ROWS, 30, rows per screen (480 px / 16 px glyph)
- ADDR_W, 12, character RAM address width; COLS*ROWS must be <= 2**ADDR_W

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- char_valid  input  1  char_ascii holds a character
- char_ascii  input  8  ASCII code
- char_ready  output  1  writer can accept; transfer occurs when char_valid && char_ready
- wr_en  output  1  character RAM write strobe
- wr_addr  output  ADDR_W  cell address = row*COLS + col
- wr_data  output  8  ASCII code written
- cursor_col  output  7  current cursor column, 0..COLS-1
- cursor_row  output  5  current cursor row, 0..ROWS-1
- busy  output  1  clear sequence in progress

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, cursor 0/0, char_ready=0, busy=1. State becomes CLR_ALL.
- Reset asserted mid-operation aborts everything and restarts CLR_ALL on the next cycle.
- CLR_ALL:
  - Writes 0x20 to addresses 0..COLS*ROWS-1, one per cycle (2400 cycles at the defaults); char_ready=0, busy=1.
  - After the last write, enters IDLE with cursor 0/0.
- IDLE:
  - char_ready=1, busy=0.
  - Latency: for an accepted printable character, wr_en pulses exactly one cycle after acceptance.
  - Throughput: printable characters that do not wrap are accepted one per cycle.
- Handling of an accepted code c:
  - 0x20..0x7E (printable): the next cycle drives wr_en=1, wr_addr=cursor address, wr_data=c. Then col+1.
    - If col was COLS-1: col=0, row=(row+1) mod ROWS, then enter CLR_LINE.
  - 0x0A (newline): col=0, row=(row+1) mod ROWS, then CLR_LINE. No character write.
  - 0x0D (carriage return): col=0. No write. Stays in IDLE.
  - 0x08 (backspace):
    - If col>0: col-1, and the next cycle writes 0x20 at the new cursor address.
    - If col=0: no-op (no reverse row wrap).
  - 0x0C (form feed): cursor 0/0, enter CLR_ALL.
  - Any other code (0x00..0x1F not listed above, 0x7F..0xFF): consumed silently, no write, cursor unchanged.
- CLR_LINE:
  - char_ready=0, busy=1.
  - Writes 0x20 to cells row*COLS+0 .. row*COLS+COLS-1 of the new row, one per cycle, then returns to IDLE.
  - char_ready rises the cycle after the last clear write.
- Wrap-around: there is no scrolling. Advancing past row ROWS-1 returns to row 0 and clears it, so the buffer behaves as a ring of lines.
- Simultaneous events: char_valid while char_ready=0 is not consumed. The source must hold char_ascii stable until accepted.
- No write to the same address occurs twice in one cycle. wr_en is 0 in every cycle in which no write is defined.

Decomposition:
- Shared package text_console_pkg holds:
  - ASCII constants: ASC_SPACE=0x20, ASC_LF=0x0A, ASC_CR=0x0D, ASC_BS=0x08, ASC_FF=0x0C
  - Default COLS/ROWS
  - State encoding: CLR_ALL, IDLE, CLR_LINE
- The renderer uses the same COLS/ROWS constants.
- No sub-module. The row*COLS address is formed by a registered row-base adder: the base advances by COLS on each row change, with no multiplier.

Test Plan:
- Reset release -> 2400 consecutive wr_en pulses with data 0x20 at addresses 0..2399, busy=1 throughout, char_ready=1 on the following cycle, cursor 0/0.
- Stream "HI" (0x48, 0x49) back-to-back -> writes 0x48@0 and 0x49@1 on consecutive cycles, each one cycle after acceptance; cursor_col=2.
- 80 printable characters from col 0 row 0 -> the last character lands at address 79, then 80 clear writes of 0x20 at 80..159, char_ready=0 for 80 cycles, cursor 0/1.
- Cursor at row 29 col 5, send 0x0A -> clear writes at 0..79, cursor 0/0.
- Backspace at col 3 row 2 -> single write of 0x20 at address 162, cursor_col=2. Backspace at col 0 -> no write, cursor unchanged.
- Send 0x0C mid-screen, then assert rst for 1 cycle during the resulting clear -> the clear restarts from address 0 and completes with a full 2400 writes. Also: send 0x07 -> consumed, no write.
